// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit: writeback selects, funct3 access codes,
// LSU FSM states and the store byte-enable helper.
package riscv_mem_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [0:0] {IDLE, WAIT_RSP} lsu_state_t;

    // Byte lanes touched by an access of the given size (funct3[1:0]) at byte offset off.
    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts and sign/zero-extends the addressed byte or halfword from a 32-bit load data word.
module lsu_load_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_data = {24'h0, w_byte};
            F3_LHU:  o_data = {16'h0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_lsu.sv
// MEM-stage load/store unit and MEM/WB register: issues data-memory requests, stalls upstream
// while an access is pending, and formats load data. Optional MISALIGN_TRAP_EN adds MisalignW.
module mem_wb_lsu
    import riscv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  ResultSrcM,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic [1:0]  ResultSrcW,
    output logic        RegWriteW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  RdW,
    output logic [31:0] PCPlus4W,
    output logic        BusErrW
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        MisalignW
`endif
);

    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

    lsu_state_t       r_state;
    lsu_state_t       w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;

    logic        w_mem_op;
    logic        w_misalign;
    logic        w_timeout;
    logic        w_req;
    logic        w_stall;
    logic        w_load_done;
    logic        w_bus_err;
    logic [31:0] w_load_data;

    assign w_mem_op  = MemWriteM | (ResultSrcM == RES_MEM);
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == LP_TIMEOUT);

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = w_mem_op &&
                        (((Funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                         ((Funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    lsu_load_align u_load_align (
        .i_rdata  (dmem_rdata),
        .i_funct3 (Funct3M),
        .i_offset (ALUResultM[1:0]),
        .o_data   (w_load_data)
    );

    // Counter only advances on stalled cycles; every completion returns it to zero.
    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = '0;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_load_done = 1'b0;
        w_bus_err   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_mem_op && !w_misalign) begin
                    if (w_timeout) begin
                        w_bus_err = 1'b1;
                    end else begin
                        w_req = 1'b1;
                        if (!dmem_req_ready) begin
                            w_stall = 1'b1;
                            w_cnt_d = r_cnt + 1'b1;
                        end else if (!MemWriteM) begin
                            w_stall   = 1'b1;
                            w_state_d = WAIT_RSP;
                        end
                    end
                end
            end
            WAIT_RSP: begin
                if (dmem_rsp_valid) begin
                    w_load_done = 1'b1;
                    w_state_d   = IDLE;
                end else if (w_timeout) begin
                    w_bus_err = 1'b1;
                    w_state_d = IDLE;
                end else begin
                    w_stall = 1'b1;
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    assign StallM         = w_stall;
    assign dmem_req_valid = w_req;
    assign dmem_we        = w_req & MemWriteM;
    assign dmem_addr      = {ALUResultM[31:2], 2'b00};
    assign dmem_be        = w_req ? store_be(Funct3M[1:0], ALUResultM[1:0]) : 4'b0000;

    always_comb begin
        case (Funct3M[1:0])
            2'b00:   dmem_wdata = {4{WriteDataM[7:0]}};
            2'b01:   dmem_wdata = {2{WriteDataM[15:0]}};
            default: dmem_wdata = WriteDataM;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            ResultSrcW <= '0;
            RegWriteW  <= 1'b0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
            PCPlus4W   <= '0;
            BusErrW    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            MisalignW  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_stall) begin
                ResultSrcW <= '0;
                RegWriteW  <= 1'b0;
                ALUResultW <= '0;
                ReadDataW  <= '0;
                RdW        <= '0;
                PCPlus4W   <= '0;
                BusErrW    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                MisalignW  <= 1'b0;
`endif
            end else begin
                ResultSrcW <= ResultSrcM;
                RegWriteW  <= RegWriteM & ~w_misalign;
                ALUResultW <= ALUResultM;
                ReadDataW  <= w_load_done ? w_load_data : 32'h0;
                RdW        <= RdM;
                PCPlus4W   <= PCPlus4M;
                BusErrW    <= w_bus_err;
`ifdef MISALIGN_TRAP_EN
                MisalignW  <= w_misalign;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_lsu.sv
// Directed self-checking bench for mem_wb_lsu with a short watchdog (TIMEOUT_CYCLES = 4).
module tb_mem_wb_lsu;

    logic        clk;
    logic        reset;
    logic [1:0]  ResultSrcM;
    logic        RegWriteM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic        StallM;
    logic [1:0]  ResultSrcW;
    logic        RegWriteW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [4:0]  RdW;
    logic [31:0] PCPlus4W;
    logic        BusErrW;
`ifdef MISALIGN_TRAP_EN
    logic        MisalignW;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mem_wb_lsu #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .ResultSrcM     (ResultSrcM),
        .RegWriteM      (RegWriteM),
        .MemWriteM      (MemWriteM),
        .Funct3M        (Funct3M),
        .ALUResultM     (ALUResultM),
        .WriteDataM     (WriteDataM),
        .RdM            (RdM),
        .PCPlus4M       (PCPlus4M),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_be        (dmem_be),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata),
        .StallM         (StallM),
        .ResultSrcW     (ResultSrcW),
        .RegWriteW      (RegWriteW),
        .ALUResultW     (ALUResultW),
        .ReadDataW      (ReadDataW),
        .RdW            (RdW),
        .PCPlus4W       (PCPlus4W),
        .BusErrW        (BusErrW)
`ifdef MISALIGN_TRAP_EN
        ,
        .MisalignW      (MisalignW)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic rw, input logic [4:0] rd, input logic [31:0] res);
        ResultSrcM = 2'b00; RegWriteM = rw; MemWriteM = 1'b0; Funct3M = 3'b000;
        ALUResultM = res; WriteDataM = 32'h0; RdM = rd; PCPlus4M = 32'h0000_0044;
    endtask

    task automatic drive_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        ResultSrcM = 2'b01; RegWriteM = 1'b1; MemWriteM = 1'b0; Funct3M = f3;
        ALUResultM = addr; WriteDataM = 32'h0; RdM = rd; PCPlus4M = 32'h0000_0080;
    endtask

    task automatic drive_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d);
        ResultSrcM = 2'b00; RegWriteM = 1'b0; MemWriteM = 1'b1; Funct3M = f3;
        ALUResultM = addr; WriteDataM = d; RdM = 5'd0; PCPlus4M = 32'h0000_0090;
    endtask

    task automatic test_reset();
        reset = 1'b0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = 32'h0;
        drive_alu(1'b1, 5'd31, 32'hFFFF_FFFF);
        #3;
        n_tests++;
        if ({RegWriteW, RdW, ALUResultW, ReadDataW, PCPlus4W, ResultSrcW, BusErrW} !== '0) begin
            n_fail++;
            $display("FAIL reset_w got rw=%b rd=%0d alu=%h rdata=%h pc4=%h rs=%b be=%b exp all 0",
                     RegWriteW, RdW, ALUResultW, ReadDataW, PCPlus4W, ResultSrcW, BusErrW);
        end
        n_tests++;
        if (dmem_req_valid !== 1'b0 || StallM !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got req=%b stall=%b exp 0 0", dmem_req_valid, StallM);
        end
        tick();
        n_tests++;
        if (RegWriteW !== 1'b0) begin
            n_fail++; $display("FAIL reset_hold got rw=%b exp 0", RegWriteW);
        end
        reset = 1'b1;
    endtask

    task automatic test_alu();
        drive_alu(1'b1, 5'd5, 32'h0000_1234);
        #1;
        n_tests++;
        if (StallM !== 1'b0 || dmem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL alu_ctrl got stall=%b req=%b exp 0 0", StallM, dmem_req_valid);
        end
        tick();
        n_tests++;
        if (RegWriteW !== 1'b1 || RdW !== 5'd5 || ALUResultW !== 32'h1234 || ReadDataW !== 32'h0
            || PCPlus4W !== 32'h44 || BusErrW !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_w got rw=%b rd=%0d alu=%h rdata=%h pc4=%h berr=%b exp 1 5 1234 0 44 0",
                     RegWriteW, RdW, ALUResultW, ReadDataW, PCPlus4W, BusErrW);
        end
    endtask

    task automatic test_store();
        dmem_req_ready = 1'b1;
        drive_store(3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        #1;
        n_tests++;
        if (dmem_req_valid !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== 4'b1111
            || dmem_addr !== 32'h100 || dmem_wdata !== 32'hDEAD_BEEF || StallM !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_req got v=%b we=%b be=%b a=%h d=%h st=%b exp 1 1 1111 100 deadbeef 0",
                     dmem_req_valid, dmem_we, dmem_be, dmem_addr, dmem_wdata, StallM);
        end
        tick();
        n_tests++;
        if (ALUResultW !== 32'h100 || RegWriteW !== 1'b0 || PCPlus4W !== 32'h90) begin
            n_fail++;
            $display("FAIL sw_w got alu=%h rw=%b pc4=%h exp 100 0 90", ALUResultW, RegWriteW, PCPlus4W);
        end
        drive_store(3'b000, 32'h0000_0101, 32'h1234_565A);
        #1;
        n_tests++;
        if (dmem_be !== 4'b0010 || dmem_wdata !== 32'h5A5A_5A5A || dmem_addr !== 32'h100
            || StallM !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_req got be=%b d=%h a=%h st=%b exp 0010 5a5a5a5a 100 0",
                     dmem_be, dmem_wdata, dmem_addr, StallM);
        end
        tick();
    endtask

    task automatic test_store_stall();
        logic [31:0] exp_alu [3];
        dmem_req_ready = 1'b0;
        drive_store(3'b001, 32'h0000_0102, 32'h0000_ABCD);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (StallM !== 1'b1 || dmem_req_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL sh_wait%0d got stall=%b req=%b exp 1 1", i, StallM, dmem_req_valid);
            end
            tick();
            exp_alu[i] = 32'h0;
            n_tests++;
            if (RegWriteW !== 1'b0 || ALUResultW !== exp_alu[i] || PCPlus4W !== 32'h0) begin
                n_fail++;
                $display("FAIL sh_bubble%0d got rw=%b alu=%h pc4=%h exp 0 0 0",
                         i, RegWriteW, ALUResultW, PCPlus4W);
            end
        end
        dmem_req_ready = 1'b1;
        #1;
        n_tests++;
        if (dmem_be !== 4'b1100 || dmem_wdata !== 32'hABCD_ABCD || StallM !== 1'b0
            || dmem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL sh_req got be=%b d=%h st=%b we=%b exp 1100 abcdabcd 0 1",
                     dmem_be, dmem_wdata, StallM, dmem_we);
        end
        tick();
        n_tests++;
        if (ALUResultW !== 32'h102 || BusErrW !== 1'b0) begin
            n_fail++; $display("FAIL sh_w got alu=%h berr=%b exp 102 0", ALUResultW, BusErrW);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3   [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
        logic [31:0] addr [6] = '{32'h103, 32'h101, 32'h102, 32'h100, 32'h104, 32'h100};
        logic [31:0] rd   [6] = '{32'h8000_0000, 32'h1234_F678, 32'h8765_4321,
                                  32'h8765_F321, 32'hCAFE_BABE, 32'h0123_4567};
        logic [31:0] exp  [6] = '{32'hFFFF_FF80, 32'h0000_00F6, 32'hFFFF_8765,
                                  32'h0000_F321, 32'hCAFE_BABE, 32'h0123_4567};
        logic [3:0]  be   [6] = '{4'b1000, 4'b0010, 4'b1100, 4'b0011, 4'b1111, 4'b1111};
        dmem_req_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_load(f3[i], addr[i], 5'd7);
            #1;
            n_tests++;
            if (dmem_req_valid !== 1'b1 || dmem_we !== 1'b0 || StallM !== 1'b1
                || dmem_be !== be[i] || dmem_addr !== {addr[i][31:2], 2'b00}) begin
                n_fail++;
                $display("FAIL ld%0d_req got v=%b we=%b st=%b be=%b a=%h exp 1 0 1 %b %h", i,
                         dmem_req_valid, dmem_we, StallM, dmem_be, dmem_addr, be[i],
                         {addr[i][31:2], 2'b00});
            end
            tick();
            dmem_rsp_valid = 1'b1;
            dmem_rdata     = rd[i];
            #1;
            n_tests++;
            if (RegWriteW !== 1'b0 || StallM !== 1'b0 || dmem_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL ld%0d_rsp got rw=%b st=%b req=%b exp 0 0 0", i, RegWriteW, StallM,
                         dmem_req_valid);
            end
            tick();
            dmem_rsp_valid = 1'b0;
            n_tests++;
            if (ReadDataW !== exp[i] || RegWriteW !== 1'b1 || RdW !== 5'd7 || ResultSrcW !== 2'b01) begin
                n_fail++;
                $display("FAIL ld%0d_w got rdata=%h rw=%b rd=%0d rs=%b exp %h 1 7 01", i,
                         ReadDataW, RegWriteW, RdW, ResultSrcW, exp[i]);
            end
        end
    endtask

    // rsp_at_timeout=1 presents the response on the same cycle the watchdog would fire.
    task automatic test_timeout(input logic rsp_at_timeout);
        dmem_req_ready = 1'b1;
        dmem_rdata     = 32'h1122_3344;
        drive_load(3'b010, 32'h0000_0200, 5'd9);
        tick();
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (StallM !== 1'b1 || dmem_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL to%0d_wait%0d got stall=%b req=%b exp 1 0", rsp_at_timeout, i,
                         StallM, dmem_req_valid);
            end
            tick();
        end
        dmem_rsp_valid = rsp_at_timeout;
        #1;
        n_tests++;
        if (StallM !== 1'b0 || dmem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL to%0d_fire got stall=%b req=%b exp 0 0", rsp_at_timeout, StallM,
                     dmem_req_valid);
        end
        tick();
        dmem_rsp_valid = 1'b0;
        n_tests++;
        if (BusErrW !== !rsp_at_timeout || ReadDataW !== (rsp_at_timeout ? 32'h1122_3344 : 32'h0)
            || RegWriteW !== 1'b1 || RdW !== 5'd9) begin
            n_fail++;
            $display("FAIL to%0d_w got berr=%b rdata=%h rw=%b rd=%0d exp %b %h 1 9", rsp_at_timeout,
                     BusErrW, ReadDataW, RegWriteW, RdW, !rsp_at_timeout,
                     rsp_at_timeout ? 32'h1122_3344 : 32'h0);
        end
        drive_alu(1'b0, 5'd3, 32'h0000_0055);
        dmem_rsp_valid = 1'b1;
        #1;
        n_tests++;
        if (StallM !== 1'b0 || dmem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL to%0d_late got stall=%b req=%b exp 0 0", rsp_at_timeout, StallM,
                     dmem_req_valid);
        end
        tick();
        dmem_rsp_valid = 1'b0;
        n_tests++;
        if (BusErrW !== 1'b0 || ReadDataW !== 32'h0 || RdW !== 5'd3 || ALUResultW !== 32'h55) begin
            n_fail++;
            $display("FAIL to%0d_late_w got berr=%b rdata=%h rd=%0d alu=%h exp 0 0 3 55",
                     rsp_at_timeout, BusErrW, ReadDataW, RdW, ALUResultW);
        end
    endtask

    task automatic test_reset_midflight();
        dmem_req_ready = 1'b1;
        drive_alu(1'b1, 5'd12, 32'h0000_0777);
        tick();
        drive_load(3'b010, 32'h0000_0300, 5'd10);
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_tests++;
        if ({RegWriteW, RdW, ALUResultW, ReadDataW, PCPlus4W, ResultSrcW, BusErrW} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_w got rw=%b rd=%0d alu=%h rdata=%h exp all 0",
                     RegWriteW, RdW, ALUResultW, ReadDataW);
        end
        #1;
        reset = 1'b1;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'hBAD0_BAD0;
        tick();
        n_tests++;
        if (StallM !== 1'b1 || dmem_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_idle got stall=%b req=%b exp 1 1", StallM, dmem_req_valid);
        end
        n_tests++;
        if (RegWriteW !== 1'b0 || ReadDataW !== 32'h0 || RdW !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_mid_stale got rw=%b rdata=%h rd=%0d exp 0 0 0",
                     RegWriteW, ReadDataW, RdW);
        end
        dmem_rsp_valid = 1'b0;
        drive_alu(1'b0, 5'd0, 32'h0);
        tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_store_stall();
        test_loads();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_lsu.md
Name: mem_wb_lsu

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Issues data-memory requests over a valid/ready request channel and a valid-only response channel; formats load data.
- Produces registered MEM/WB outputs for the writeback mux.
- Asserts StallM while a memory access is pending so upstream pipeline registers hold.

Parameters:
- TIMEOUT_CYCLES, 255: wait cycles (request or response) before forcing completion with BusErrW=1; 0 disables the watchdog.
- CNT_W, 8: width of the watchdog counter; must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ResultSrcM  in  2  00 ALU, 01 load data, 10 PC+4
- RegWriteM  in  1  register write enable from EX/MEM
- MemWriteM  in  1  store enable from EX/MEM
- Funct3M  in  3  access size/sign
- ALUResultM  in  32  effective address / ALU result
- WriteDataM  in  32  store data
- RdM  in  5  destination register
- PCPlus4M  in  32  link value
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({ALUResultM[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_rsp_valid  in  1  load data valid
- dmem_rdata  in  32  load data word
- StallM  out  1  hold IF..EX/MEM stages
- ResultSrcW  out  2  registered
- RegWriteW  out  1  registered
- ALUResultW  out  32  registered
- ReadDataW  out  32  formatted load data, registered
- RdW  out  5  registered
- PCPlus4W  out  32  registered
- BusErrW  out  1  registered; watchdog fired for this instruction

Behaviour:
- Reset (reset=0, async): state IDLE, counter 0, all W outputs 0, dmem_req_valid 0.
- Mem op = MemWriteM | (ResultSrcM==01).
- FSM states:
  - IDLE
    - No mem op: StallM=0; W registers capture M inputs next edge (1-cycle latency, ReadDataW=0).
    - Mem op: dmem_req_valid=1 combinationally; dmem_we=MemWriteM.
    - Not ready: StallM=1; counter increments; W loads a bubble (RegWriteW=0, BusErrW=0, other W fields 0); stay IDLE.
    - Ready and store: StallM=0; W captures M fields; stay IDLE. Stores are posted.
    - Ready and load: StallM=1; W loads a bubble; go WAIT_RSP; counter cleared.
  - WAIT_RSP
    - dmem_req_valid=0.
    - rsp_valid=0: StallM=1; W bubble; counter increments.
    - rsp_valid=1: StallM=0; W captures M fields plus ReadDataW=format(dmem_rdata); go IDLE.
- Load format (byte offset = ALUResultM[1:0]):
  - 000 lb: sign-extend byte.
  - 001 lh: sign-extend half at ALUResultM[1].
  - 010 lw: full word.
  - 100 lbu: zero-extend byte.
  - 101 lhu: zero-extend half.
  - Other codes: ReadDataW = full word.
- Store lanes:
  - sb: be=0001<<off, wdata={4{byte}}.
  - sh: be=0011<<(2*ALUResultM[1]), wdata={2{half}}.
  - sw: be=1111.
- dmem_be=0 when dmem_req_valid=0.
- Watchdog (TIMEOUT_CYCLES>0): counter reaching TIMEOUT_CYCLES forces completion that cycle.
  - StallM=0, dmem_req_valid=0, ReadDataW=0, BusErrW=1, W captures M fields; go IDLE.
  - BusErrW is 1 only for that W cycle.
- Boundary cases:
  - rsp_valid in IDLE: ignored, including stale responses after a mid-transaction reset.
  - rsp_valid on the same cycle as timeout: response wins, BusErrW=0.
  - Only one outstanding load at a time; no new request is issued in WAIT_RSP.
  - Inputs must stay stable while StallM=1; upstream guarantees this.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misaligned lh/lhu/sh (off[0]=1) or lw/sw (off!=0): no bus request; StallM=0.
  - W captures M fields with RegWriteW=0 and extra output MisalignW=1 for one cycle.
- Undefined:
  - Address bits below the access size are ignored; lanes are computed as specified.
  - MisalignW port absent.

Decomposition:
- Package riscv_mem_pkg holds:
  - ResultSrc encodings (RES_ALU, RES_MEM, RES_PC4).
  - Funct3 load/store codes.
  - lsu_state_t enum {IDLE, WAIT_RSP}.
- One combinational sub-module lsu_load_align: dmem_rdata, Funct3, offset -> ReadData.
- Store-lane logic stays inline.

Test Plan:
- ALU op, RegWriteM=1, RdM=5, ALUResultM=0x1234 -> next edge RegWriteW=1, RdW=5, ALUResultW=0x1234, StallM=0 throughout.
- sw to 0x100, WriteDataM=0xDEADBEEF, ready=1 -> same cycle req_valid=1, we=1, be=1111, addr=0x100, no stall.
- lb from 0x103, ready=1, rsp one cycle later with rdata=0x80000000 -> StallM high 1 cycle, then ReadDataW=0xFFFFFF80.
- sh to 0x102, data 0x0000ABCD, ready low 3 cycles -> StallM=1 and W bubbles for 3 cycles, then be=1100, wdata=0xABCDABCD.
- lw, TIMEOUT_CYCLES=4, no rsp -> StallM clears after counter hits 4, BusErrW=1, ReadDataW=0; late rsp_valid ignored.
- Assert reset in WAIT_RSP -> all W outputs 0 immediately, state IDLE, subsequent rsp_valid causes no W update.
